fan_mode_pwm: RTL and testbench
===============================

# fan_mode_pwm

Converts the fan's one-hot speed-mode ring (OFF/LOW/MID/HIGH) into a glitch-free PWM motor drive. Duty changes ramp 1 % at a time, so mode changes never jump the motor. The block sits downstream of the button-driven mode counter and drives the fan driver pin and the mode LEDs. It also flags any ring value that is not a legal one-hot code.

## Interface
- PRESCALE, 40, clk cycles per PWM tick (≥2)
- RAMP_PERIODS, 2, PWM periods between 1 % duty steps (≥1)
- DUTY_LOW, 33, LOW-mode duty in %
- DUTY_MID, 66, MID-mode duty in %
- DUTY_HIGH, 100, HIGH-mode duty in %
- clk  in  1  system clock
- reset_p  in  1  asynchronous, active-high reset
- ring  in  4  one-hot mode: 0001 OFF, 0010 LOW, 0100 MID, 1000 HIGH
- pwm  out  1  fan drive, registered
- duty  out  7  current applied duty, 0..100 %
- mode_led  out  4  registered copy of the last legal ring value
- busy  out  1  high while duty ≠ target
- fault  out  1  high while ring is not a legal one-hot code

## Operation
- **Target decode**, registered each clk:
  - 0001 → 0; 0010 → DUTY_LOW; 0100 → DUTY_MID; 1000 → DUTY_HIGH.
  - Any other value → target 0, fault=1, and mode_led holds its previous value.
- **Tick:** the prescaler pulses `tick` for 1 clk every PRESCALE clks.
- **PWM counter:** pwm_cnt runs 0..99 and advances on tick. It wraps 99→0.
  - period_end = tick && pwm_cnt==99.
- **PWM output:** pwm <= (pwm_cnt < duty), registered.
  - duty=0 → constant low.
  - duty=100 → constant high.
- **State machine** (2-bit), evaluated every clk from the registered duty and target:
  - IDLE: duty==0 and target==0.
  - HOLD: duty==target≠0.
  - RAMP_UP: duty<target.
  - RAMP_DN: duty>target.
  - busy = RAMP_UP | RAMP_DN.
- **Ramp counter:**
  - Cleared in IDLE/HOLD.
  - In RAMP states it increments on period_end.
  - When it equals RAMP_PERIODS-1 at a period_end, duty moves ±1 toward target and the counter clears.
- **Duty update rule:** duty changes only at period_end, so no PWM period is ever truncated.
- **Target change mid-ramp:**
  - Duty continues from its current value toward the new target; the ramp counter is not cleared.
  - Reversal is allowed (RAMP_UP→RAMP_DN directly).
- **Width/arith:** duty is 7 bits unsigned and saturates at 0 and 100. Duty parameters >100 are clamped to 100 at decode.

## Timing
- **Reset (async):**
  - pwm=0, duty=0, busy=0, fault=0, mode_led=4'b0001.
  - pwm_cnt=0, prescaler=0, ramp counter=0, state=IDLE.
  - pwm drops immediately on reset assertion. Release is synchronous to the next clk edge.
- **Ring to outputs:**
  - A ring change reaches target, mode_led and fault 1 clk later.
  - busy and state follow 1 clk after that (2 clk total).
- **First duty step** after a new target: at the RAMP_PERIODS-th period_end following entry to a RAMP state.
- **Full ramp time:** |Δduty| × RAMP_PERIODS × 100 × PRESCALE clks, ±1 period of alignment.
- **pwm latency:** reflects a new duty starting the period that begins after the updating period_end, with 1 clk registered latency.
- **Illegal ring:** treated as OFF. Duty ramps down and does not cut to 0 instantly; fault clears 1 clk after a legal code returns.

## Structure
- **Package fan_pkg:**
  - mode one-hot constants (MODE_OFF/LOW/MID/HIGH)
  - state enum (IDLE, HOLD, RAMP_UP, RAMP_DN)
  - PWM_STEPS=100
  - default duty constants
- **Sub-module fan_pwm_prescaler:** parameter PRESCALE, ports clk/reset_p/tick. It is reusable by other fan timing blocks.
- **Top:** decode, PWM counter, ramp FSM and output registers live in fan_mode_pwm.

## Test plan
Bench parameters: PRESCALE=4, RAMP_PERIODS=1 (400 clks per period) unless noted.
- **Reset state:** assert reset_p mid-ramp at duty=20 → pwm=0 and duty=0 immediately; mode_led=0001, busy=0.
- **Ramp up from OFF:** ring 0001→0010 → busy after 2 clks; duty +1 per 400 clks; duty=33 after 33 periods, then HOLD, busy=0; pwm high for 33×4 clks per period.
- **Reversal mid-ramp:** ring 0100 until duty=40, then 0001 → duty 40→0 at 1 %/period; pwm never truncated mid-period; ends in IDLE, pwm constant low.
- **HIGH saturation:** ring 1000, ramp complete → duty=100, pwm constant high with no low glitch at the pwm_cnt wrap.
- **Illegal code:** ring 0110 during HOLD at 66 → fault=1 after 1 clk; mode_led stays 0100; duty ramps toward 0. Ring 0010 → fault=0; duty ramps down to 33.
- **Slow ramp:** RAMP_PERIODS=3, ring 0001→0010 → first step at the 3rd period_end; duty=33 after 99 periods.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared fan-control definitions: mode codes, ramp states,
// PWM resolution and default duty levels.
package fan_pkg;

  localparam int PWM_STEPS = 100;

  localparam logic [3:0] MODE_OFF  = 4'b0001;
  localparam logic [3:0] MODE_LOW  = 4'b0010;
  localparam logic [3:0] MODE_MID  = 4'b0100;
  localparam logic [3:0] MODE_HIGH = 4'b1000;

  localparam int DUTY_LOW_DEF  = 33;
  localparam int DUTY_MID_DEF  = 66;
  localparam int DUTY_HIGH_DEF = 100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RAMP_UP = 2'd2,
    RAMP_DN = 2'd3
  } fan_state_e;

  function automatic logic [6:0] clamp_duty(
    input int d
  );
    if (d > PWM_STEPS) begin
      return 7'(PWM_STEPS);
    end else if (d < 0) begin
      return 7'd0;
    end else begin
      return 7'(d);
    end
  endfunction

endpackage

// File: rtl/fan_pwm_prescaler.sv
// Free-running divider: tick is high for one clk
// out of every PRESCALE clks.
module fan_pwm_prescaler #(
  parameter int PRESCALE = 40
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fan_mode_pwm.sv
// One-hot fan mode to ramped PWM drive; duty only moves
// at PWM period boundaries so no period is truncated.
module fan_mode_pwm
  import fan_pkg::*;
#(
  parameter int PRESCALE     = 40,
  parameter int RAMP_PERIODS = 2,
  parameter int DUTY_LOW     = DUTY_LOW_DEF,
  parameter int DUTY_MID     = DUTY_MID_DEF,
  parameter int DUTY_HIGH    = DUTY_HIGH_DEF
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [3:0] ring,
  output logic       pwm,
  output logic [6:0] duty,
  output logic [3:0] mode_led,
  output logic       busy,
  output logic       fault
);

  localparam logic [6:0] D_LOW  = clamp_duty(DUTY_LOW);
  localparam logic [6:0] D_MID  = clamp_duty(DUTY_MID);
  localparam logic [6:0] D_HIGH = clamp_duty(DUTY_HIGH);
  localparam logic [6:0] D_MAX  = 7'(PWM_STEPS);
  localparam logic [6:0] C_LAST = 7'(PWM_STEPS - 1);

  localparam int RW = $clog2(RAMP_PERIODS + 1);
  localparam logic [RW-1:0] R_LAST = RW'(RAMP_PERIODS - 1);

  logic          tick;
  logic          period_end;

  logic [6:0]    tgt_q, tgt_d;
  logic [3:0]    led_q, led_d;
  logic          fault_q, fault_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [6:0]    duty_q, duty_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic          pwm_q, pwm_d;
  fan_state_e    state_q, state_d;

  fan_pwm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk    (clk),
    .reset_p(reset_p),
    .tick   (tick)
  );

  // Illegal ring codes behave as OFF but keep the LEDs.
  always_comb begin
    tgt_d   = 7'd0;
    fault_d = 1'b0;
    led_d   = ring;
    unique case (ring)
      MODE_OFF:  tgt_d = 7'd0;
      MODE_LOW:  tgt_d = D_LOW;
      MODE_MID:  tgt_d = D_MID;
      MODE_HIGH: tgt_d = D_HIGH;
      default: begin
        fault_d = 1'b1;
        led_d   = led_q;
      end
    endcase
  end

  assign period_end = tick && (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = period_end ? 7'd0 : cnt_q + 7'd1;
    end
  end

  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      duty_q < tgt_q:
        state_d = RAMP_UP;
      duty_q > tgt_q:
        state_d = RAMP_DN;
      (duty_q == tgt_q) && (duty_q == 7'd0):
        state_d = IDLE;
      (duty_q == tgt_q) && (duty_q != 7'd0):
        state_d = HOLD;
    endcase
  end

  // Direction is re-checked against the live target so a
  // freshly reversed target never overshoots.
  always_comb begin
    ramp_d = ramp_q;
    duty_d = duty_q;
    unique case (state_q)
      IDLE, HOLD: ramp_d = '0;
      RAMP_UP, RAMP_DN: begin
        if (period_end) begin
          if (ramp_q == R_LAST) begin
            ramp_d = '0;
            if (state_q == RAMP_UP &&
                duty_q < tgt_q &&
                duty_q < D_MAX) begin
              duty_d = duty_q + 7'd1;
            end else if (state_q == RAMP_DN &&
                         duty_q > tgt_q) begin
              duty_d = duty_q - 7'd1;
            end
          end else begin
            ramp_d = ramp_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign pwm_d = (cnt_q < duty_q);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      tgt_q   <= 7'd0;
      led_q   <= MODE_OFF;
      fault_q <= 1'b0;
      cnt_q   <= 7'd0;
      duty_q  <= 7'd0;
      ramp_q  <= '0;
      pwm_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      tgt_q   <= tgt_d;
      led_q   <= led_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      ramp_q  <= ramp_d;
      pwm_q   <= pwm_d;
      state_q <= state_d;
    end
  end

  assign pwm      = pwm_q;
  assign duty     = duty_q;
  assign mode_led = led_q;
  assign fault    = fault_q;
  assign busy     = (state_q == RAMP_UP) ||
                    (state_q == RAMP_DN);

endmodule

// File: tb/tb_fan_mode_pwm.sv
// Bench for fan_mode_pwm: three instances (main, HIGH, slow
// ramp) checked period by period against arithmetic expectations.
module tb_fan_mode_pwm;

  localparam logic [3:0] M_OFF  = 4'b0001;
  localparam logic [3:0] M_LOW  = 4'b0010;
  localparam logic [3:0] M_MID  = 4'b0100;
  localparam logic [3:0] M_HIGH = 4'b1000;
  localparam int PS  = 4;
  localparam int PER = 100 * PS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_m, rst_h, rst_s;
  logic [3:0] ring_m, ring_h, ring_s;
  logic       pwm_m, pwm_h, pwm_s;
  logic [6:0] duty_m, duty_h, duty_s;
  logic [3:0] led_m, led_h, led_s;
  logic       busy_m, busy_h, busy_s;
  logic       fault_m, fault_h, fault_s;

  int ec_m, ec_h, ec_s;
  int n_chk = 0;
  int n_fail = 0;

  fan_mode_pwm #(.PRESCALE(PS), .RAMP_PERIODS(1)) u_m (
    .clk(clk), .reset_p(rst_m), .ring(ring_m),
    .pwm(pwm_m), .duty(duty_m), .mode_led(led_m),
    .busy(busy_m), .fault(fault_m)
  );

  fan_mode_pwm #(.PRESCALE(PS), .RAMP_PERIODS(1)) u_h (
    .clk(clk), .reset_p(rst_h), .ring(ring_h),
    .pwm(pwm_h), .duty(duty_h), .mode_led(led_h),
    .busy(busy_h), .fault(fault_h)
  );

  fan_mode_pwm #(.PRESCALE(PS), .RAMP_PERIODS(3)) u_s (
    .clk(clk), .reset_p(rst_s), .ring(ring_s),
    .pwm(pwm_s), .duty(duty_s), .mode_led(led_s),
    .busy(busy_s), .fault(fault_s)
  );

  // Clock edges since reset release; period ends fall on
  // every multiple of 100*PRESCALE.
  always @(posedge clk or posedge rst_m)
    if (rst_m) ec_m <= 0; else ec_m <= ec_m + 1;
  always @(posedge clk or posedge rst_h)
    if (rst_h) ec_h <= 0; else ec_h <= ec_h + 1;
  always @(posedge clk or posedge rst_s)
    if (rst_s) ec_s <= 0; else ec_s <= ec_s + 1;

  task automatic wait_pe(input int which, output int hi);
    int e;
    int n;
    hi = 0;
    n  = 0;
    e  = 1;
    do begin
      @(posedge clk);
      #1;
      n++;
      case (which)
        0: begin e = ec_m; hi += int'(pwm_m); end
        1: begin e = ec_h; hi += int'(pwm_h); end
        default: begin e = ec_s; hi += int'(pwm_s); end
      endcase
    end while ((e % PER) != 0 && n < 2 * PER);
    if (n >= 2 * PER) begin
      n_chk++;
      n_fail++;
      $display("FAIL pe_timeout dut=%0d: waited %0d, need <= %0d",
               which, n, PER);
    end
  endtask

  task automatic test_reset;
    int hi;
    int k;
    logic [13:0] got;
    #1;
    got = {pwm_m, duty_m, busy_m, fault_m, led_m};
    n_chk++;
    if (got !== {1'b0, 7'd0, 1'b0, 1'b0, M_OFF}) begin
      n_fail++;
      $display("FAIL reset_init: got %b expected %b", got,
               {1'b0, 7'd0, 1'b0, 1'b0, M_OFF});
    end
    @(negedge clk);
    rst_m = 1'b0;
    wait_pe(0, hi);
    ring_m = M_MID;
    for (int p = 1; p <= 20; p++) begin
      wait_pe(0, hi);
      n_chk++;
      if (int'(duty_m) !== p) begin
        n_fail++;
        $display("FAIL reset_ramp p=%0d: got %0d expected %0d",
                 p, duty_m, p);
      end
    end
    k = $urandom_range(2, 60);
    repeat (k) @(posedge clk);
    #1;
    n_chk++;
    if (pwm_m !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_pwm k=%0d: got %b expected 1", k, pwm_m);
    end
    rst_m = 1'b1;
    #1;
    got = {pwm_m, duty_m, busy_m, fault_m, led_m};
    n_chk++;
    if (got !== {1'b0, 7'd0, 1'b0, 1'b0, M_OFF}) begin
      n_fail++;
      $display("FAIL reset_midramp: got %b expected %b", got,
               {1'b0, 7'd0, 1'b0, 1'b0, M_OFF});
    end
    ring_m = M_OFF;
    @(negedge clk);
    rst_m = 1'b0;
  endtask

  task automatic test_ramp_up;
    int hi;
    wait_pe(0, hi);
    ring_m = M_LOW;
    @(posedge clk);
    #1;
    n_chk++;
    if (busy_m !== 1'b0 || led_m !== M_LOW) begin
      n_fail++;
      $display("FAIL ramp_up_1clk: got busy=%b led=%b expected 0/%b",
               busy_m, led_m, M_LOW);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (busy_m !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_up_busy: got %b expected 1", busy_m);
    end
    for (int p = 1; p <= 33; p++) begin
      wait_pe(0, hi);
      n_chk++;
      if (int'(duty_m) !== p || hi !== 4 * (p - 1)) begin
        n_fail++;
        $display("FAIL ramp_up p=%0d: got duty=%0d hi=%0d expected %0d/%0d",
                 p, duty_m, hi, p, 4 * (p - 1));
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_up_hold: got busy=%b expected 0", busy_m);
    end
    wait_pe(0, hi);
    wait_pe(0, hi);
    n_chk++;
    if (hi !== 33 * PS || int'(duty_m) !== 33) begin
      n_fail++;
      $display("FAIL ramp_up_width: got hi=%0d duty=%0d expected %0d/33",
               hi, duty_m, 33 * PS);
    end
  endtask

  task automatic test_illegal;
    int hi;
    int n;
    logic [3:0] bad [6];
    logic [3:0] code;
    bad = '{4'b0110, 4'b0000, 4'b0011, 4'b1111, 4'b0101, 4'b1010};
    ring_m = M_MID;
    for (int p = 1; p <= 33; p++) begin
      wait_pe(0, hi);
      n_chk++;
      if (int'(duty_m) !== 33 + p) begin
        n_fail++;
        $display("FAIL to_mid p=%0d: got %0d expected %0d",
                 p, duty_m, 33 + p);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_hold: got busy=%b expected 0", busy_m);
    end
    wait_pe(0, hi);
    code = bad[$urandom_range(0, 5)];
    ring_m = code;
    @(posedge clk);
    #1;
    n_chk++;
    if (fault_m !== 1'b1 || led_m !== M_MID) begin
      n_fail++;
      $display("FAIL illegal %b: got fault=%b led=%b expected 1/%b",
               code, fault_m, led_m, M_MID);
    end
    n = $urandom_range(2, 6);
    for (int p = 1; p <= n; p++) begin
      wait_pe(0, hi);
      n_chk++;
      if (int'(duty_m) !== 66 - p || busy_m !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_ramp p=%0d: got %0d/%b expected %0d/1",
                 p, duty_m, busy_m, 66 - p);
      end
    end
    ring_m = M_LOW;
    @(posedge clk);
    #1;
    n_chk++;
    if (fault_m !== 1'b0 || led_m !== M_LOW) begin
      n_fail++;
      $display("FAIL illegal_clear: got fault=%b led=%b expected 0/%b",
               fault_m, led_m, M_LOW);
    end
    for (int p = 1; p <= 33 - n; p++) begin
      wait_pe(0, hi);
      n_chk++;
      if (int'(duty_m) !== 66 - n - p) begin
        n_fail++;
        $display("FAIL to_low p=%0d: got %0d expected %0d",
                 p, duty_m, 66 - n - p);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (busy_m !== 1'b0 || int'(duty_m) !== 33) begin
      n_fail++;
      $display("FAIL low_hold: got busy=%b duty=%0d expected 0/33",
               busy_m, duty_m);
    end
  endtask

  task automatic test_reversal;
    int hi;
    wait_pe(0, hi);
    ring_m = M_MID;
    for (int p = 1; p <= 7; p++) begin
      wait_pe(0, hi);
    end
    n_chk++;
    if (int'(duty_m) !== 40 || busy_m !== 1'b1) begin
      n_fail++;
      $display("FAIL rev_start: got %0d/%b expected 40/1", duty_m, busy_m);
    end
    ring_m = M_OFF;
    for (int p = 1; p <= 40; p++) begin
      wait_pe(0, hi);
      n_chk++;
      if (int'(duty_m) !== 40 - p || hi !== 4 * (41 - p)) begin
        n_fail++;
        $display("FAIL rev_down p=%0d: got duty=%0d hi=%0d expected %0d/%0d",
                 p, duty_m, hi, 40 - p, 4 * (41 - p));
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL rev_idle: got busy=%b expected 0", busy_m);
    end
    wait_pe(0, hi);
    wait_pe(0, hi);
    n_chk++;
    if (hi !== 0) begin
      n_fail++;
      $display("FAIL rev_low: got hi=%0d expected 0", hi);
    end
  endtask

  task automatic test_high;
    int hi;
    @(negedge clk);
    rst_h = 1'b0;
    ring_h = M_HIGH;
    for (int p = 1; p <= 100; p++) begin
      wait_pe(1, hi);
      n_chk++;
      if (int'(duty_h) !== p || hi !== 4 * (p - 1)) begin
        n_fail++;
        $display("FAIL high p=%0d: got duty=%0d hi=%0d expected %0d/%0d",
                 p, duty_h, hi, p, 4 * (p - 1));
      end
    end
    for (int r = 0; r < 2; r++) begin
      wait_pe(1, hi);
      n_chk++;
      if (hi !== PER || int'(duty_h) !== 100) begin
        n_fail++;
        $display("FAIL high_sat r=%0d: got hi=%0d duty=%0d expected %0d/100",
                 r, hi, duty_h, PER);
      end
    end
    n_chk++;
    if (busy_h !== 1'b0 || fault_h !== 1'b0) begin
      n_fail++;
      $display("FAIL high_hold: got busy=%b fault=%b expected 0/0",
               busy_h, fault_h);
    end
  endtask

  task automatic test_slow_ramp;
    int hi;
    @(negedge clk);
    rst_s = 1'b0;
    ring_s = M_LOW;
    for (int p = 1; p <= 99; p++) begin
      wait_pe(2, hi);
      n_chk++;
      if (int'(duty_s) !== p / 3 || hi !== 4 * ((p - 1) / 3) ||
          busy_s !== 1'b1) begin
        n_fail++;
        $display("FAIL slow p=%0d: got duty=%0d hi=%0d busy=%b expected %0d/%0d/1",
                 p, duty_s, hi, busy_s, p / 3, 4 * ((p - 1) / 3));
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (busy_s !== 1'b0 || int'(duty_s) !== 33) begin
      n_fail++;
      $display("FAIL slow_hold: got busy=%b duty=%0d expected 0/33",
               busy_s, duty_s);
    end
  endtask

  initial begin
    rst_m  = 1'b1;
    rst_h  = 1'b1;
    rst_s  = 1'b1;
    ring_m = M_OFF;
    ring_h = M_OFF;
    ring_s = M_OFF;
    fork
      begin
        test_reset;
        test_ramp_up;
        test_illegal;
        test_reversal;
      end
      test_high;
      test_slow_ramp;
    join
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
